approx_rec_mult_seq: RTL and testbench

APPROX_REC_MULT_SEQ -- requirements
Module: approx_rec_mult_seq

---
 rtl/approx_rec_mult_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_approx_rec_mult_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_rec_mult_seq.sv
// -----------------------------------------------------------------------------
// approx_rec_mult_seq
//
// Sequential approximate recursive multiplier. Each operand is split into
// 4-bit nibbles. Every nibble pair (a_i, b_j) forms a 4x4 tile of weight
// w = i + j. Tiles are accumulated one per clock, i-major, into an exact
// 2*WIDTH-bit sum. The mode chooses which tiles use the exact 4x4 product and
// which use cheaper approximations:
//   EX4 : exact 4x4 product
//   OR4 : partial-product columns OR-ed instead of added (bit 7 always 0)
//   N2  : OR4 for bits 0..5, top two bits rebuilt from a3b3 and a2b2
//
//   mode 00 : every tile EX4
//   mode 01 : w = 0 OR4, every other tile EX4
//   mode 10 : w = 0 OR4, w = 1 N2, w >= 2 EX4
//   mode 11 : w = 0 OR4, 1 <= w <= 2K-3 N2, w = 2K-2 EX4
//
// Handshake: an operand pair is taken when in_valid && in_ready. After K*K
// cycles the product is shown on y/y_mode with out_valid high and stays there
// until out_ready. In DONE a new pair can be taken on the same edge that
// retires the current product.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair offered
//   in_ready   block can take an operand pair
//   a, b       unsigned operands, WIDTH bits
//   mode       approximation mode, sampled when the pair is taken
//   out_valid  product available
//   out_ready  consumer takes the product
//   y          product, 2*WIDTH bits
//   y_mode     mode that produced y
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module approx_rec_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   y,
   output logic [1:0]           y_mode
);

   localparam int K  = WIDTH / 4;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   // i + j never exceeds 2K-2, which always fits in one extra bit
   localparam int WW = IW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Tile arithmetic
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] ex4(input logic [3:0] x, input logic [3:0] z);
      logic [7:0] r;
      r = {4'b0000, x} * {4'b0000, z};
      return r;
   endfunction

   // Column k collects every partial product x[p]&z[q] with p+q = k; the
   // column is OR-ed, so carries are dropped and bit 7 can never be set.
   function automatic logic [7:0] or4(input logic [3:0] x, input logic [3:0] z);
      logic [7:0] r;
      r = '0;
      for (int p = 0; p < 4; p++) begin
         for (int q = 0; q < 4; q++) begin
            r[p+q] = r[p+q] | (x[p] & z[q]);
         end
      end
      return r;
   endfunction

   // The two upper bits are rebuilt from the diagonal terms so that the
   // dominant 3x3 contribution keeps its magnitude.
   function automatic logic [7:0] n2(input logic [3:0] x, input logic [3:0] z);
      logic [7:0] r;
      logic       d33;
      logic       d22;
      r    = or4(x, z);
      d33  = x[3] & z[3];
      d22  = x[2] & z[2];
      r[6] = d33 & ~d22;
      r[7] = d33 & d22;
      return r;
   endfunction

   function automatic logic [7:0] tile_val(input logic [1:0]    m,
                                           input logic [WW-1:0] wt,
                                           input logic [3:0]    x,
                                           input logic [3:0]    z);
      logic [7:0] r;
      r = ex4(x, z);
      case (m)
         2'b00: r = ex4(x, z);
         2'b01: begin
            if (wt == '0) r = or4(x, z);
         end
         2'b10: begin
            if (wt == '0)                r = or4(x, z);
            else if (wt == WW'(1))       r = n2(x, z);
         end
         2'b11: begin
            if (wt == '0)                r = or4(x, z);
            else if (wt <= WW'(2*K-3))   r = n2(x, z);
         end
         default: r = ex4(x, z);
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [1:0]           mode_q, mode_d;
   logic [IW-1:0]        i_q, i_d;
   logic [IW-1:0]        j_q, j_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   y_q, y_d;
   logic [1:0]           ymode_q, ymode_d;

   // ---------------------------------------------------------------------------
   // Current tile
   // ---------------------------------------------------------------------------
   logic [3:0]           a_nib;
   logic [3:0]           b_nib;
   logic [WW-1:0]        w;
   logic [7:0]           tile;
   logic [2*WIDTH-1:0]   tile_sh;
   logic [2*WIDTH-1:0]   acc_sum;
   logic                 last_tile;

   always_comb begin
      a_nib     = a_q[{i_q, 2'b00} +: 4];
      b_nib     = b_q[{j_q, 2'b00} +: 4];
      w         = {1'b0, i_q} + {1'b0, j_q};
      tile      = tile_val(mode_q, w, a_nib, b_nib);
      tile_sh   = {{(2*WIDTH-8){1'b0}}, tile} << {w, 2'b00};
      acc_sum   = acc_q + tile_sh;
      last_tile = (i_q == IW'(K-1)) && (j_q == IW'(K-1));
   end

   // ---------------------------------------------------------------------------
   // Next state and handshake outputs
   // ---------------------------------------------------------------------------
   logic accept;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      mode_d    = mode_q;
      i_d       = i_q;
      j_d       = j_q;
      acc_d     = acc_q;
      y_d       = y_q;
      ymode_d   = ymode_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         RUN: begin
            acc_d = acc_sum;
            if (last_tile) begin
               y_d     = acc_sum;
               ymode_d = mode_q;
               state_d = DONE;
            end else if (j_q == IW'(K-1)) begin
               j_d = '0;
               i_d = i_q + IW'(1);
            end else begin
               j_d = j_q + IW'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // The retiring edge can also take the next pair.
            in_ready  = out_ready;
            if (out_ready) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      accept = in_valid && in_ready;
      if (accept) begin
         a_d     = a;
         b_d     = b;
         mode_d  = mode;
         acc_d   = '0;
         i_d     = '0;
         j_d     = '0;
         state_d = RUN;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         ymode_q <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         ymode_q <= ymode_d;
      end
      // Operand registers are only read in RUN, which always follows a load.
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
   end

   assign y      = y_q;
   assign y_mode = ymode_q;

endmodule

// File: tb/tb_approx_rec_mult_seq.sv
`timescale 1ns/1ps

module tb_approx_rec_mult_seq;

   logic        clk;
   logic        rst;

   logic        iv8, ir8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [1:0]  m8, ym8;
   logic [15:0] y8;

   logic        iv16, ir16, ov16, or16;
   logic [15:0] a16, b16;
   logic [1:0]  m16, ym16;
   logic [31:0] y16;

   int checks;
   int failures;

   approx_rec_mult_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .mode(m8),
      .out_valid(ov8), .out_ready(or8),
      .y(y8), .y_mode(ym8)
   );

   approx_rec_mult_seq #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .mode(m16),
      .out_valid(ov16), .out_ready(or16),
      .y(y16), .y_mode(ym16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Reference model: sum of nibble tiles with the per-weight kind rules
   // ---------------------------------------------------------------------------
   function automatic int or_prod(input int x, input int z);
      int t;
      t = 0;
      for (int k = 0; k < 7; k++) begin
         for (int p = 0; p <= k; p++) begin
            if (p < 4 && (k - p) < 4 && ((x >> p) & 1) == 1 && ((z >> (k - p)) & 1) == 1)
               t = t | (1 << k);
         end
      end
      return t;
   endfunction

   function automatic logic [63:0] model(input logic [15:0] ta, input logic [15:0] tb_,
                                         input logic [1:0] m, input int width);
      logic [63:0] sum;
      int k, an, bn, w, t, kind; // kind: 0 exact, 1 or, 2 n2
      k = width / 4;
      sum = 64'd0;
      for (int i = 0; i < k; i++) begin
         for (int j = 0; j < k; j++) begin
            an = int'((ta >> (4*i)) & 16'hF);
            bn = int'((tb_ >> (4*j)) & 16'hF);
            w  = i + j;
            if (m == 2'b00)      kind = 0;
            else if (w == 0)     kind = 1;
            else if (m == 2'b01) kind = 0;
            else if (m == 2'b10) kind = (w == 1) ? 2 : 0;
            else                 kind = (w <= 2*k - 3) ? 2 : 0;
            if (kind == 0) t = an * bn;
            else if (kind == 1) t = or_prod(an, bn);
            else begin
               t = or_prod(an, bn) % 64;
               if (an >= 8 && bn >= 8)
                  t = t + ((((an >> 2) & 1) == 1 && ((bn >> 2) & 1) == 1) ? 128 : 64);
            end
            sum = sum + (64'(t) << (4*w));
         end
      end
      return sum;
   endfunction

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
      end
   endtask

   task automatic drive(input bit wide, input logic v, input logic [15:0] ta,
                        input logic [15:0] tb_, input logic [1:0] tm);
      if (wide) begin
         iv16 = v; a16 = ta; b16 = tb_; m16 = tm;
      end else begin
         iv8 = v; a8 = ta[7:0]; b8 = tb_[7:0]; m8 = tm;
      end
   endtask

   task automatic set_or(input bit wide, input logic v);
      if (wide) or16 = v;
      else      or8  = v;
   endtask

   function automatic logic get_ov(input bit wide);
      return wide ? ov16 : ov8;
   endfunction

   function automatic logic get_ir(input bit wide);
      return wide ? ir16 : ir8;
   endfunction

   function automatic logic [63:0] get_y(input bit wide);
      return wide ? 64'(y16) : 64'(y8);
   endfunction

   function automatic logic [1:0] get_ym(input bit wide);
      return wide ? ym16 : ym8;
   endfunction

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   // Waits for out_valid after an accept edge; returns edges elapsed.
   task automatic wait_valid(input bit wide, output int cyc);
      cyc = 0;
      while (!get_ov(wide) && cyc < 64) begin
         clk_step();
         cyc++;
      end
   endtask

   task automatic run_txn(input bit wide, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic [1:0] tm, input logic [63:0] exp_y, input string nm);
      int cyc;
      int lat;
      lat = wide ? 16 : 4;
      chk({nm, " in_ready"}, 64'(get_ir(wide)), 64'd1);
      drive(wide, 1'b1, ta, tb_, tm);
      clk_step();
      // Operands change right after the accept edge and must not matter.
      drive(wide, 1'b0, 16'($urandom), 16'($urandom), 2'($urandom));
      wait_valid(wide, cyc);
      chk({nm, " latency"}, 64'(cyc), 64'(lat));
      chk({nm, " y"}, get_y(wide), exp_y);
      chk({nm, " y_mode"}, 64'(get_ym(wide)), 64'(tm));
      set_or(wide, 1'b1);
      clk_step();
      set_or(wide, 1'b0);
      chk({nm, " release"}, 64'(get_ov(wide)), 64'd0);
   endtask

   typedef struct {
      bit          wide;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  m;
      logic [63:0] y;
      string       nm;
   } vec_t;

   vec_t vt[10];

   initial begin
      logic [15:0] ra, rb;
      logic [1:0]  rm;
      logic [63:0] ey;
      int          cyc;
      int          seen;

      checks   = 0;
      failures = 0;

      vt[0] = '{0, 16'h00FF, 16'h00FF, 2'b00, 64'd65025,      "w8 m00 FFxFF"};
      vt[1] = '{0, 16'h000F, 16'h000F, 2'b01, 64'd127,        "w8 m01 0Fx0F"};
      vt[2] = '{0, 16'h00FF, 16'h00FF, 2'b10, 64'd63839,      "w8 m10 FFxFF"};
      vt[3] = '{0, 16'h00FF, 16'h00FF, 2'b11, 64'd63839,      "w8 m11 FFxFF"};
      vt[4] = '{0, 16'h00FF, 16'h00FF, 2'b01, 64'd64927,      "w8 m01 FFxFF"};
      vt[5] = '{0, 16'h0012, 16'h0034, 2'b00, 64'd936,        "w8 m00 12x34"};
      vt[6] = '{0, 16'h0000, 16'h00C3, 2'b11, 64'd0,          "w8 m11 zero"};
      vt[7] = '{1, 16'hFFFF, 16'hFFFF, 2'b00, 64'hFFFE0001,   "w16 m00 max"};
      vt[8] = '{1, 16'hFFFF, 16'hFFFF, 2'b11, 64'd4216264031, "w16 m11 max"};
      vt[9] = '{1, 16'hFFFF, 16'hFFFF, 2'b10, 64'd4294835039, "w16 m10 max"};

      rst = 1'b1;
      iv8 = 1'b0; a8 = '0; b8 = '0; m8 = '0; or8 = 1'b0;
      iv16 = 1'b0; a16 = '0; b16 = '0; m16 = '0; or16 = 1'b0;
      clk_step();
      clk_step();
      rst = 1'b0;

      // Reset state
      chk("rst w8 in_ready",   64'(ir8), 64'd1);
      chk("rst w8 out_valid",  64'(ov8), 64'd0);
      chk("rst w8 y",          64'(y8),  64'd0);
      chk("rst w8 y_mode",     64'(ym8), 64'd0);
      chk("rst w16 in_ready",  64'(ir16), 64'd1);
      chk("rst w16 out_valid", 64'(ov16), 64'd0);
      chk("rst w16 y",         64'(y16),  64'd0);

      // Directed vectors
      for (int n = 0; n < 10; n++)
         run_txn(vt[n].wide, vt[n].a, vt[n].b, vt[n].m, vt[n].y, vt[n].nm);

      // Random vectors against the model
      for (int n = 0; n < 40; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rm = 2'($urandom);
         if (n < 28) begin
            ra[15:8] = '0;
            rb[15:8] = '0;
            run_txn(1'b0, ra, rb, rm, model(ra, rb, rm, 8), "rand w8");
         end else begin
            run_txn(1'b1, ra, rb, rm, model(ra, rb, rm, 16), "rand w16");
         end
      end

      // Stall in DONE, then back-to-back accept on the retiring edge
      chk("b2b idle in_ready", 64'(ir8), 64'd1);
      drive(1'b0, 1'b1, 16'h009C, 16'h0057, 2'b00);
      clk_step();
      // in_valid during RUN must be ignored
      drive(1'b0, 1'b1, 16'h00AA, 16'h0055, 2'b11);
      wait_valid(1'b0, cyc);
      chk("b2b first latency", 64'(cyc), 64'd4);
      drive(1'b0, 1'b0, 16'h0001, 16'h0001, 2'b01);
      ey = model(16'h009C, 16'h0057, 2'b00, 8);
      for (int h = 0; h < 5; h++) begin
         chk("stall y",         64'(y8),  ey);
         chk("stall out_valid", 64'(ov8), 64'd1);
         chk("stall in_ready",  64'(ir8), 64'd0);
         clk_step();
      end
      chk("stall y_mode", 64'(ym8), 64'd0);
      or8 = 1'b1;
      drive(1'b0, 1'b1, 16'h00FF, 16'h00FF, 2'b10);
      clk_step();
      or8 = 1'b0;
      drive(1'b0, 1'b0, 16'h0033, 16'h0077, 2'b00);
      chk("b2b running out_valid", 64'(ov8), 64'd0);
      chk("b2b running in_ready",  64'(ir8), 64'd0);
      wait_valid(1'b0, cyc);
      chk("b2b second latency", 64'(cyc), 64'd4);
      chk("b2b second y",       64'(y8),  64'd63839);
      chk("b2b second y_mode",  64'(ym8), 64'd2);
      or8 = 1'b1;
      clk_step();
      or8 = 1'b0;

      // Reset two cycles after accept aborts the operation
      drive(1'b0, 1'b1, 16'h000F, 16'h000F, 2'b01);
      clk_step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      clk_step();
      rst = 1'b1;
      clk_step();
      rst = 1'b0;
      chk("abort run out_valid", 64'(ov8), 64'd0);
      chk("abort run in_ready",  64'(ir8), 64'd1);
      chk("abort run y",         64'(y8),  64'd0);
      chk("abort run y_mode",    64'(ym8), 64'd0);
      seen = 0;
      for (int h = 0; h < 8; h++) begin
         clk_step();
         if (ov8) seen++;
      end
      chk("abort run no product", 64'(seen), 64'd0);

      // Reset while a product is waiting in DONE
      drive(1'b0, 1'b1, 16'h00FF, 16'h00FF, 2'b11);
      clk_step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      wait_valid(1'b0, cyc);
      chk("abort done latency", 64'(cyc), 64'd4);
      chk("abort done y before", 64'(y8), 64'd63839);
      rst = 1'b1;
      clk_step();
      rst = 1'b0;
      chk("abort done out_valid", 64'(ov8), 64'd0);
      chk("abort done y",         64'(y8),  64'd0);
      chk("abort done y_mode",    64'(ym8), 64'd0);
      chk("abort done in_ready",  64'(ir8), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
